fb_scanout: RTL and testbench

Reads the 256x176 frame buffer back out and streams every pixel to the VGA adapter in raster order. It is the read-side counterpart of the game datapath, which writes map, link and enemy sprites into the frame buffer. Control pulses start after all draw states finish, then waits for done before returning to idle. The block hides the frame-buffer read latency with a valid/coordinate pipeline, so exactly one VGA write is issued per pixel.

---
 rtl/fb_scanout.sv | 155 +++++++++++++++
 tb/tb_fb_scanout.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: walks the 256x176 buffer in raster order and streams each
// pixel to the VGA adapter, with a valid/coordinate pipeline hiding the read latency.
module fb_scanout #(
    parameter int FB_WIDTH     = 256,
    parameter int FB_HEIGHT    = 176,
    parameter int READ_LATENCY = 1,
    parameter int X_OFFSET     = 32,
    parameter int Y_OFFSET     = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  fb_q,
    output logic [15:0] fb_address,
    output logic        fb_rden,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [5:0]  vga_colour,
    output logic        vga_write,
    output logic        busy,
    output logic        done
);

    localparam int XW = $clog2(FB_WIDTH);
    localparam int YW = 16 - XW;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t          state_q;
    logic [XW-1:0]   x_cnt_q;
    logic [YW-1:0]   y_cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            last_px;

    logic            vld_p0, vld_p1;
    logic [XW-1:0]   x_p0, x_p1;
    logic [YW-1:0]   y_p0, y_p1;

    logic            vld_al;
    logic [XW-1:0]   x_al;
    logic [YW-1:0]   y_al;
    logic            pipe_busy;

    logic [8:0]      vga_x_q;
    logic [7:0]      vga_y_q;
    logic [5:0]      vga_colour_q;
    logic            vga_write_q;

    function automatic logic [8:0] scr_x(input logic [XW-1:0] x);
        return 9'(x) + 9'(X_OFFSET);
    endfunction

    function automatic logic [7:0] scr_y(input logic [YW-1:0] y);
        return 8'(y) + 8'(Y_OFFSET);
    endfunction

    assign last_px    = (x_cnt_q == XW'(FB_WIDTH - 1)) && (y_cnt_q == YW'(FB_HEIGHT - 1));
    assign fb_address = {y_cnt_q, x_cnt_q};
    assign fb_rden    = (state_q == SCAN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        x_cnt_q <= '0;
                        y_cnt_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (last_px) begin
                        state_q <= DRAIN;
                        x_cnt_q <= '0;
                        y_cnt_q <= '0;
                    end else if (x_cnt_q == XW'(FB_WIDTH - 1)) begin
                        x_cnt_q <= '0;
                        y_cnt_q <= y_cnt_q + YW'(1);
                    end else begin
                        x_cnt_q <= x_cnt_q + XW'(1);
                    end
                end
                DRAIN: begin
                    // Once no valid remains in flight, the last pixel is being written now.
                    if (!pipe_busy) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage p0/p1: carry valid and coordinates alongside the frame-buffer read
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= (state_q == SCAN);
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clock) begin
        x_p0 <= x_cnt_q;
        y_p0 <= y_cnt_q;
        x_p1 <= x_p0;
        y_p1 <= y_p0;
    end

    assign vld_al    = (READ_LATENCY == 2) ? vld_p1 : vld_p0;
    assign x_al      = (READ_LATENCY == 2) ? x_p1   : x_p0;
    assign y_al      = (READ_LATENCY == 2) ? y_p1   : y_p0;
    assign pipe_busy = vld_p0 | vld_al;

    // Output stage: register the aligned pixel for the VGA adapter
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_write_q  <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            vga_write_q <= vld_al;
            if (vld_al) begin
                vga_x_q      <= scr_x(x_al);
                vga_y_q      <= scr_y(y_al);
                vga_colour_q <= fb_q;
            end
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_write  = vga_write_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: one instance at read latency 1, one at latency 2,
// each fed by a synchronous frame-buffer model holding (x ^ y) & 6'h3F.
module tb_fb_scanout;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset1, start1, reset2, start2;
    logic [5:0]  fb_q1, fb_q2, q2_s1;
    logic [15:0] addr1, addr2;
    logic        rden1, rden2;
    logic [8:0]  vx1, vx2;
    logic [7:0]  vy1, vy2;
    logic [5:0]  col1, col2;
    logic        wr1, wr2, busy1, busy2, done1, done2;

    int total = 0;
    int bad   = 0;
    int wc1 = 0, wc2 = 0, dc1 = 0, dc2 = 0;

    fb_scanout #(.READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset1), .start(start1), .fb_q(fb_q1),
        .fb_address(addr1), .fb_rden(rden1), .vga_x(vx1), .vga_y(vy1),
        .vga_colour(col1), .vga_write(wr1), .busy(busy1), .done(done1)
    );

    fb_scanout #(.READ_LATENCY(2)) dut2 (
        .clock(clock), .reset(reset2), .start(start2), .fb_q(fb_q2),
        .fb_address(addr2), .fb_rden(rden2), .vga_x(vx2), .vga_y(vy2),
        .vga_colour(col2), .vga_write(wr2), .busy(busy2), .done(done2)
    );

    function automatic logic [5:0] pix_colour(input logic [15:0] a);
        logic [7:0] t;
        t = a[7:0] ^ a[15:8];
        return t[5:0];
    endfunction

    always @(posedge clock) begin
        fb_q1 <= pix_colour(addr1);
        q2_s1 <= pix_colour(addr2);
        fb_q2 <= q2_s1;
    end

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle(input string p, input int cyc, input int rl,
                               input logic [15:0] addr, input logic rden,
                               input logic [8:0] vx, input logic [7:0] vy, input logic [5:0] col,
                               input logic wr, input logic bsy, input logic dn);
        int  k, x, y;
        logic ew;
        chk({p, "_addr"}, cyc, 32'(addr), (cyc >= 1 && cyc <= 45056) ? 32'(cyc - 1) : 32'd0);
        chk({p, "_rden"}, cyc, 32'(rden), 32'(cyc >= 1 && cyc <= 45056));
        chk({p, "_busy"}, cyc, 32'(bsy), 32'(cyc >= 1 && cyc <= 45058 + rl));
        chk({p, "_done"}, cyc, 32'(dn), 32'(cyc == 45058 + rl));
        ew = (cyc >= 2 + rl) && (cyc <= 45057 + rl);
        chk({p, "_write"}, cyc, 32'(wr), 32'(ew));
        if (ew) begin
            k = cyc - 2 - rl;
            x = k % 256;
            y = k / 256;
            chk({p, "_vx"}, cyc, 32'(vx), 32'(32 + x));
            chk({p, "_vy"}, cyc, 32'(vy), 32'(32 + y));
            chk({p, "_col"}, cyc, 32'(col), 32'((x ^ y) & 63));
        end
    endtask

    task automatic check_pix(input string tag, input int cyc, input logic wr,
                             input logic [8:0] vx, input logic [7:0] vy, input logic [5:0] col,
                             input int ex, input int ey, input int ec);
        chk({tag, "_wr"}, cyc, 32'(wr), 32'd1);
        chk({tag, "_x"}, cyc, 32'(vx), 32'(ex));
        chk({tag, "_y"}, cyc, 32'(vy), 32'(ey));
        chk({tag, "_c"}, cyc, 32'(col), 32'(ec));
    endtask

    initial begin
        reset1 = 1'b1; start1 = 1'b1;
        reset2 = 1'b1; start2 = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_x", 0, 32'(vx1), 32'd0);
        chk("rst_y", 0, 32'(vy1), 32'd0);
        chk("rst_col", 0, 32'(col1), 32'd0);
        chk("rst_wr", 0, 32'(wr1), 32'd0);
        chk("rst_busy", 0, 32'(busy1), 32'd0);
        chk("rst_done", 0, 32'(done1), 32'd0);
        chk("rst_rden", 0, 32'(rden1), 32'd0);
        chk("rst_addr", 0, 32'(addr1), 32'd0);
        chk("rst2_wr", 0, 32'(wr2), 32'd0);
        chk("rst2_busy", 0, 32'(busy2), 32'd0);
        reset1 = 1'b0;
        reset2 = 1'b0; start2 = 1'b0;

        // Scan started straight out of reset, then reset mid-scan at cycle 20000
        for (int cyc = 1; cyc <= 20000; cyc++) begin
            @(negedge clock);
            check_cycle("a1", cyc, 1, addr1, rden1, vx1, vy1, col1, wr1, busy1, done1);
            if (cyc == 3) check_pix("a_first", cyc, wr1, vx1, vy1, col1, 32, 32, 0);
            if (cyc % 5000 == 0) begin
                chk("a2_idle_wr", cyc, 32'(wr2), 32'd0);
                chk("a2_idle_busy", cyc, 32'(busy2), 32'd0);
            end
            if (cyc == 1) start1 = 1'b0;
        end
        reset1 = 1'b1;
        @(negedge clock);
        chk("mid_rst_wr", 20001, 32'(wr1), 32'd0);
        chk("mid_rst_busy", 20001, 32'(busy1), 32'd0);
        chk("mid_rst_addr", 20001, 32'(addr1), 32'd0);
        chk("mid_rst_rden", 20001, 32'(rden1), 32'd0);
        chk("mid_rst_vx", 20001, 32'(vx1), 32'd0);
        reset1 = 1'b0;
        @(negedge clock);
        chk("post_rst_wr", 20002, 32'(wr1), 32'd0);
        chk("post_rst_busy", 20002, 32'(busy1), 32'd0);

        // Full scans on both instances, with start pulses while busy
        start1 = 1'b1; start2 = 1'b1;
        for (int cyc = 1; cyc <= 45062; cyc++) begin
            @(negedge clock);
            check_cycle("b1", cyc, 1, addr1, rden1, vx1, vy1, col1, wr1, busy1, done1);
            check_cycle("b2", cyc, 2, addr2, rden2, vx2, vy2, col2, wr2, busy2, done2);
            chk("b1_done_and_wr", cyc, 32'(done1 & wr1), 32'd0);
            chk("b2_done_and_wr", cyc, 32'(done2 & wr2), 32'd0);
            wc1 += int'(wr1); dc1 += int'(done1);
            wc2 += int'(wr2); dc2 += int'(done2);
            case (cyc)
                2:     chk("b1_c2_nowr", cyc, 32'(wr1), 32'd0);
                3: begin
                    check_pix("b1_first", cyc, wr1, vx1, vy1, col1, 32, 32, 0);
                    chk("b2_c3_nowr", cyc, 32'(wr2), 32'd0);
                end
                4:     check_pix("b2_first", cyc, wr2, vx2, vy2, col2, 32, 32, 0);
                258:   check_pix("b1_px255", cyc, wr1, vx1, vy1, col1, 287, 32, 63);
                259:   check_pix("b1_px256", cyc, wr1, vx1, vy1, col1, 32, 33, 1);
                260:   check_pix("b1_px257", cyc, wr1, vx1, vy1, col1, 33, 33, 0);
                45058: check_pix("b1_last", cyc, wr1, vx1, vy1, col1, 287, 207, 16);
                45059: begin
                    chk("b1_done", cyc, 32'(done1), 32'd1);
                    check_pix("b2_last", cyc, wr2, vx2, vy2, col2, 287, 207, 16);
                end
                45060: begin
                    chk("b1_idle_busy", cyc, 32'(busy1), 32'd0);
                    chk("b2_done", cyc, 32'(done2), 32'd1);
                end
                default: ;
            endcase
            if (cyc == 1 || cyc == 101 || cyc == 30001) begin
                start1 = 1'b0; start2 = 1'b0;
            end
            if (cyc == 100 || cyc == 30000) begin
                start1 = 1'b1; start2 = 1'b1;
            end
        end
        chk("b1_write_count", 45062, 32'(wc1), 32'd45056);
        chk("b1_done_count", 45062, 32'(dc1), 32'd1);
        chk("b2_write_count", 45062, 32'(wc2), 32'd45056);
        chk("b2_done_count", 45062, 32'(dc2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
